// File: rtl/mv_tile_acc.sv
// Pipelined signed matrix-vector tile engine that accumulates M row dot products across a beat group.
// Define MV_OUT_SAT_EN to clamp results to OUT_W and add the out_sat port; otherwise results wrap.
module mv_tile_acc #(
   parameter int M     = 16,
   parameter int N     = 16,
   parameter int DW    = 16,
   parameter int ACC_W = 48,
   parameter int OUT_W = 32,
   parameter int TW    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [M*N*DW-1:0]    in_mat,
   input  logic [N*DW-1:0]      in_vec,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [M*OUT_W-1:0]   out_vec,
   output logic [TW-1:0]        out_tiles
`ifdef MV_OUT_SAT_EN
   ,
   output logic [M-1:0]         out_sat
`endif
);

   localparam int PW = 2*DW;
   localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic                     stall;
   logic                     load_res;
   logic                     s1_valid_q, s1_last_q;
   logic                     s2_valid_q, s2_last_q;
   logic                     first_q;
   logic                     out_valid_q, out_valid_d;
   logic signed [PW-1:0]     prod_d [M*N];
   logic signed [PW-1:0]     prod_q [M*N];
   logic signed [ACC_W-1:0]  sum_d  [M];
   logic signed [ACC_W-1:0]  sum_q  [M];
   logic signed [ACC_W-1:0]  acc_d  [M];
   logic signed [ACC_W-1:0]  acc_q  [M];
   logic [TW-1:0]            cnt_q, cnt_inc;
   logic [TW-1:0]            out_tiles_q;
   logic [M*OUT_W-1:0]       out_vec_d, out_vec_q;
`ifdef MV_OUT_SAT_EN
   logic [M-1:0]             sat_d, sat_q;
`endif

   // A held output freezes the whole pipeline, so nothing in flight is ever dropped.
   assign stall     = out_valid_q && !out_ready;
   assign in_ready  = !stall;
   assign load_res  = !stall && s2_valid_q && s2_last_q;
   assign cnt_inc   = (cnt_q == {TW{1'b1}}) ? cnt_q : cnt_q + TW'(1);
   assign out_valid = out_valid_q;
   assign out_vec   = out_vec_q;
   assign out_tiles = out_tiles_q;
`ifdef MV_OUT_SAT_EN
   assign out_sat   = sat_q;
`endif

   always_comb begin : p_mult
      logic signed [PW-1:0] a, b;
      a = '0;
      b = '0;
      for (int i = 0; i < M*N; i++) begin
         a = {{DW{in_mat[i*DW+DW-1]}}, in_mat[i*DW +: DW]};
         b = {{DW{in_vec[(i%N)*DW+DW-1]}}, in_vec[(i%N)*DW +: DW]};
         prod_d[i] = a * b;
      end
   end

   always_comb begin : p_sum
      for (int r = 0; r < M; r++) begin
         sum_d[r] = '0;
         for (int c = 0; c < N; c++) begin
            sum_d[r] = sum_d[r] + {{(ACC_W-PW){prod_q[r*N+c][PW-1]}}, prod_q[r*N+c]};
         end
      end
   end

   always_comb begin : p_acc
      for (int r = 0; r < M; r++) begin
         acc_d[r] = (first_q ? '0 : acc_q[r]) + sum_q[r];
      end
   end

   always_comb begin : p_conv
      out_vec_d = '0;
`ifdef MV_OUT_SAT_EN
      sat_d = '0;
`endif
      for (int r = 0; r < M; r++) begin
`ifdef MV_OUT_SAT_EN
         if (acc_d[r] > OUT_MAX) begin
            out_vec_d[r*OUT_W +: OUT_W] = OUT_MAX[OUT_W-1:0];
            sat_d[r] = 1'b1;
         end else if (acc_d[r] < OUT_MIN) begin
            out_vec_d[r*OUT_W +: OUT_W] = OUT_MIN[OUT_W-1:0];
            sat_d[r] = 1'b1;
         end else begin
            out_vec_d[r*OUT_W +: OUT_W] = acc_d[r][OUT_W-1:0];
         end
`else
         out_vec_d[r*OUT_W +: OUT_W] = acc_d[r][OUT_W-1:0];
`endif
      end
   end

   // A new result landing on the handshake edge keeps valid high with no bubble.
   always_comb begin : p_out_valid
      out_valid_d = out_valid_q;
      if (load_res)       out_valid_d = 1'b1;
      else if (out_ready) out_valid_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_last_q   <= 1'b0;
         first_q     <= 1'b1;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_vec_q   <= '0;
         out_tiles_q <= '0;
`ifdef MV_OUT_SAT_EN
         sat_q       <= '0;
`endif
         for (int i = 0; i < M*N; i++) prod_q[i] <= '0;
         for (int r = 0; r < M; r++) begin
            sum_q[r] <= '0;
            acc_q[r] <= '0;
         end
      end else begin
         out_valid_q <= out_valid_d;
         if (!stall) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
               s1_last_q <= in_last;
               for (int i = 0; i < M*N; i++) prod_q[i] <= prod_d[i];
            end
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            for (int r = 0; r < M; r++) sum_q[r] <= sum_d[r];
            if (s2_valid_q) begin
               if (s2_last_q) begin
                  out_vec_q   <= out_vec_d;
                  out_tiles_q <= cnt_inc;
`ifdef MV_OUT_SAT_EN
                  sat_q       <= sat_d;
`endif
                  for (int r = 0; r < M; r++) acc_q[r] <= '0;
                  first_q <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  for (int r = 0; r < M; r++) acc_q[r] <= acc_d[r];
                  first_q <= 1'b0;
                  cnt_q   <= cnt_inc;
               end
            end
         end
      end
   end

endmodule

// File: doc/mv_tile_acc.md
Name: mv_tile_acc

Overview:
- Parametrised, pipelined signed-integer matrix-vector engine; successor to the fixed 16x16 single-shot matrix unit.
- Each accepted beat carries one M x N matrix tile and one N-element vector slice, and produces M partial dot products.
- Partials accumulate across a group of beats (K-dimension tiling) until in_last.
- Final M results go out through a valid/ready output register; sits between the feature/weight buffer readers and the writeback stage.

Parameters:
- M, 16, output rows per tile
- N, 16, columns per tile (vector slice length)
- DW, 16, signed element width
- ACC_W, 48, accumulator width per row; must be >= 2*DW+clog2(N)
- OUT_W, 32, output element width
- TW, 8, width of beat counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&&in_ready
- in_mat  in  M*N*DW  row r, column c at bits [(r*N+c)*DW +: DW]
- in_vec  in  N*DW  element c at [c*DW +: DW]
- in_last  in  1  final beat of current accumulation group
- out_valid  out  1  result held valid
- out_ready  in  1  downstream accepts result
- out_vec  out  M*OUT_W  row r at [r*OUT_W +: OUT_W]
- out_tiles  out  TW  number of beats in the reported group

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_vec=0, out_tiles=0, in_ready=1 after release; all stage valids=0; accumulators=0; beat counter=0; first-beat flag=1.
- stall = out_valid && !out_ready; in_ready = !stall. While stalled, every pipeline stage holds its contents, including valid, last and data.
- S1 (edge of acceptance): register M*N signed products, each 2*DW bits, plus valid and last.
- S2: per row, sum N products, sign-extended to ACC_W, into a register; valid and last carried along.
- S3: per row, acc_next = (first ? 0 : acc) + sum, all in ACC_W with wrap.
  - Non-last beat: acc <= acc_next, first <= 0, beat count +1.
  - Last beat: out_vec <= convert(acc_next), out_tiles <= count+1, out_valid <= 1, acc <= 0, first <= 1, count <= 0.
- Latency: last beat accepted at edge t gives out_valid=1 after edge t+2. Throughput is 1 beat/cycle when not stalled.
- Output handshake: out_valid stays high and out_vec/out_tiles stay stable until out_valid&&out_ready.
  - Same-edge case: if a new last beat reaches S3 at that same edge, the new result loads and out_valid stays 1 with no bubble.
  - Otherwise out_valid <= 0.
- Single-beat group (in_last on first beat): result is the tile product alone; out_tiles=1.
- Beat counter saturates at 2^TW-1. Accumulation continues correctly past saturation.
- in_valid=0 cycles inside a group insert bubbles only; the accumulator is preserved.
- convert without feature: low OUT_W bits of acc_next (two's-complement wrap).
- Reset mid-group or mid-stall discards partial sums and any pending output; no result is emitted.
- in_mat, in_vec and in_last are don't-care when in_valid=0.

Optional Feature:
- Macro MV_OUT_SAT_EN.
- When defined: convert clamps each row to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- When defined: output port out_sat (M bits) is added, bit r=1 if row r was clamped, and it is registered with out_vec.
- When undefined: wrap truncation only, and the out_sat port is absent.

Test Plan:
- M=2,N=2,DW=8: rows [1,2],[3,4], vec [5,6], in_last=1 -> after 3 cycles out_vec={39,17} (row1=39,row0=17), out_tiles=1.
- Same tile sent 3 beats, last on third -> out_vec={117,51}, out_tiles=3; no out_valid after beats 1-2.
- Last result pending with out_ready=0 for 5 cycles, 2 more beats offered -> in_ready=0 throughout, out_vec stable; after release the next group result is correct.
- Signed case: row0=[-128,-128], vec=[-128,127], single beat -> row0 = 16384-16256 = 128.
- OUT_W=8, row0=[127,127], vec=[127,127] -> 32258. Without macro: out=2 (0x02). With MV_OUT_SAT_EN: out=127, out_sat[0]=1.
- rst_n pulsed low mid-group after 2 beats, then a 1-beat group [1,1]x[1,1] with M=1 -> out=2, out_tiles=1, and no stale partial sum is included.
